// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared encodings and IO page map for mem_io_responder
package mem_io_responder_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_rw_e;

  localparam logic [1:0] IO_PAGE     = 2'b11;
  localparam logic [2:0] IO_TX_OFS   = 3'h0;
  localparam logic [2:0] IO_STAT_OFS = 3'h4;

  // Bit positions inside the status byte at IO_STAT_OFS.
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_RXAV_BIT  = 2;

  function automatic logic [7:0] status_byte(input logic full, input logic ovf, input logic rxav);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_FULL_BIT] = full;
    s[STAT_OVF_BIT]  = ovf;
    s[STAT_RXAV_BIT] = rxav;
    return s;
  endfunction

endpackage

// File: rtl/mem_io_responder_io_tx_fifo.sv
// rtl/mem_io_responder_io_tx_fifo.sv - show-ahead byte FIFO for the IO transmit path
module io_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_ok = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - RAM and IO page responder; MEM_IO_RX_EN adds the RX holding register
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        iMEM_rw,
  input  logic [31:0] iMEM_addr,
  input  logic [7:0]  iMEM_dt,
  output logic [7:0]  oMEM_dt,
  output logic        oIO_buffer_full,
  output logic        oTX_valid,
  output logic [7:0]  oTX_dt,
  input  logic        iTX_ready,
  output logic        oIO_overflow,
  output logic        oSIM_halt
`ifdef MEM_IO_RX_EN
  ,
  input  logic        iRX_valid,
  input  logic [7:0]  iRX_dt
`endif
);

  localparam int CW = $clog2(TXQ_DEPTH) + 1;

  logic [7:0]    mem [2**RAM_AW];
  logic          io_sel;
  logic          is_write;
  logic          is_read;
  logic [2:0]    io_ofs;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_push_ok;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_avail;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;
  logic          unused_addr;

  assign unused_addr = ^iMEM_addr[31:18];

  assign io_sel   = (iMEM_addr[17:16] == IO_PAGE);
  assign is_write = rdy && (mem_rw_e'(iMEM_rw) == MEM_WRITE);
  assign is_read  = rdy && (mem_rw_e'(iMEM_rw) == MEM_READ);
  assign io_ofs   = iMEM_addr[2:0];

  assign tx_push  = is_write && io_sel && (io_ofs == IO_TX_OFS);
  assign tx_pop   = oTX_valid && iTX_ready && rdy;

  io_tx_fifo #(
    .DEPTH(TXQ_DEPTH)
  ) u_txq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (iMEM_dt),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count),
    .push_ok   (tx_push_ok)
  );

  assign oTX_valid       = (tx_count != '0);
  // Masked so the stale head entry never shows while the queue is empty.
  assign oTX_dt          = oTX_valid ? tx_head : 8'h00;
  // Two-byte margin absorbs the store already in flight when the stall is seen.
  assign oIO_buffer_full = (tx_count >= CW'(TXQ_DEPTH - 2));

  always_ff @(posedge clk) begin
    if (is_write && !io_sel) mem[iMEM_addr[RAM_AW-1:0]] <= iMEM_dt;
  end

  always_comb begin
    rd_byte = 8'h00;
    if (io_sel) begin
      case (io_ofs)
        IO_TX_OFS:   rd_byte = rx_byte;
        IO_STAT_OFS: rd_byte = status_byte(oIO_buffer_full, oIO_overflow, rx_avail);
        default:     rd_byte = 8'h00;
      endcase
    end else begin
      rd_byte = mem[iMEM_addr[RAM_AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oMEM_dt      <= 8'h00;
      oIO_overflow <= 1'b0;
      oSIM_halt    <= 1'b0;
    end else begin
      if (is_read) oMEM_dt <= rd_byte;
      if (tx_push && !tx_push_ok) oIO_overflow <= 1'b1;
      if (is_write && io_sel && (io_ofs == IO_STAT_OFS)) oSIM_halt <= 1'b1;
    end
  end

`ifdef MEM_IO_RX_EN
  logic [7:0] rx_hold;
  logic       rx_take;

  assign rx_take = is_read && io_sel && (io_ofs == IO_TX_OFS);
  assign rx_byte = rx_avail ? rx_hold : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hold  <= 8'h00;
      rx_avail <= 1'b0;
    end else if (rdy) begin
      if (rx_take) begin
        rx_avail <= 1'b0;
      end else if (iRX_valid && !rx_avail) begin
        rx_hold  <= iRX_dt;
        rx_avail <= 1'b1;
      end
    end
  end
`else
  assign rx_avail = 1'b0;
  assign rx_byte  = 8'h00;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed bench with a queue-based reference model
module tb_mem_io_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rw = 1'b0;
  logic [31:0] addr = 32'h0003_0008;
  logic [7:0]  wdt = 8'h00;
  logic [7:0]  mem_dt;
  logic        buf_full;
  logic        tx_valid;
  logic [7:0]  tx_dt;
  logic        tx_ready = 1'b0;
  logic        overflow;
  logic        halt;

  int n_cmp = 0;
  int n_fail = 0;

  mem_io_responder #(.RAM_AW(17), .TXQ_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .iMEM_rw         (rw),
    .iMEM_addr       (addr),
    .iMEM_dt         (wdt),
    .oMEM_dt         (mem_dt),
    .oIO_buffer_full (buf_full),
    .oTX_valid       (tx_valid),
    .oTX_dt          (tx_dt),
    .iTX_ready       (tx_ready),
    .oIO_overflow    (overflow),
    .oSIM_halt       (halt)
`ifdef MEM_IO_RX_EN
    ,
    .iRX_valid       (1'b0),
    .iRX_dt          (8'h00)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: RAM as a sparse array, TX FIFO as a queue.
  logic [7:0] m_ram [int];
  logic [7:0] m_q [$];
  logic [7:0] m_dt = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_halt = 1'b0;

  function automatic logic m_full();
    return m_q.size() >= DEPTH - 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_dt = 8'h00;
      m_ovf = 1'b0;
      m_halt = 1'b0;
    end else if (rdy) begin
      logic io;
      logic popping;
      io = (addr[17:16] == 2'b11);
      if (!rw) begin
        if (!io) m_dt = m_ram.exists(int'(addr[16:0])) ? m_ram[int'(addr[16:0])] : 8'hxx;
        else if (addr[2:0] == 3'd4) m_dt = {5'b0, 1'b0, m_ovf, m_full()};
        else m_dt = 8'h00;
      end
      popping = (m_q.size() != 0) && tx_ready;
      if (popping) void'(m_q.pop_front());
      if (rw && !io) m_ram[int'(addr[16:0])] = wdt;
      if (rw && io && addr[2:0] == 3'd0) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdt);
        else m_ovf = 1'b1;
      end
      if (rw && io && addr[2:0] == 3'd4) m_halt = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("mem_dt",   mem_dt,          m_dt);
    chk("tx_valid", {7'b0, tx_valid}, {7'b0, m_q.size() != 0});
    chk("tx_dt",    tx_dt,           (m_q.size() != 0) ? m_q[0] : 8'h00);
    chk("buf_full", {7'b0, buf_full}, {7'b0, m_full()});
    chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
    chk("halt",     {7'b0, halt},     {7'b0, m_halt});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rw = 1'b0;
    addr = 32'h0003_0008;
    wdt = 8'h00;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    rw = 1'b1;
    addr = a;
    wdt = d;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    rw = 1'b0;
    addr = a;
    cyc();
    idle();
  endtask

  logic [7:0] seq [4];

  initial begin
    seq[0] = 8'h13; seq[1] = 8'h05; seq[2] = 8'h10; seq[3] = 8'h00;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_mem_dt", mem_dt, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_buf_full", {7'b0, buf_full}, 8'h00);

    wr(32'h10, 8'hA5);
    rd(32'h10);
    chk("raw_a5", mem_dt, 8'hA5);

    for (int i = 0; i < 4; i++) wr(32'(i), seq[i]);
    for (int i = 0; i < 4; i++) begin
      rd(32'(i));
      chk("seq_rd", mem_dt, seq[i]);
    end

    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr(32'h0003_0000, 8'(8'h40 + i));
      if (i == 12) chk("full_at_13", {7'b0, buf_full}, 8'h00);
      if (i == 13) chk("full_at_14", {7'b0, buf_full}, 8'h01);
    end
    chk("no_ovf_at_16", {7'b0, overflow}, 8'h00);

    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h50);
    tx_ready = 1'b0;
    chk("full_pushpop_ovf", {7'b0, overflow}, 8'h00);
    chk("full_pushpop_head", tx_dt, 8'h41);

    wr(32'h0003_0000, 8'h51);
    chk("ovf_set", {7'b0, overflow}, 8'h01);
    rd(32'h0003_0004);
    chk("status", mem_dt, 8'h03);

    rdy = 1'b0;
    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h99);
    rd(32'h0001_0000);
    cyc();
    chk("hold_head", tx_dt, 8'h41);
    chk("hold_mem_dt", mem_dt, 8'h03);
    chk("hold_valid", {7'b0, tx_valid}, 8'h01);
    rdy = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      chk("drain", tx_dt, 8'(8'h41 + i));
      cyc();
    end
    chk("drained", {7'b0, tx_valid}, 8'h00);

    wr(32'h0003_0004, 8'hFF);
    chk("halt_set", {7'b0, halt}, 8'h01);

    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h77);
    chk("empty_pushpop_valid", {7'b0, tx_valid}, 8'h01);
    chk("empty_pushpop_dt", tx_dt, 8'h77);
    cyc();
    chk("empty_pushpop_gone", {7'b0, tx_valid}, 8'h00);

    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h61);
    wr(32'h0003_0000, 8'h62);
    wr(32'h0003_0000, 8'h63);
    tx_ready = 1'b1;
    cyc();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {7'b0, tx_valid}, 8'h00);
    chk("arst_dt", tx_dt, 8'h00);
    chk("arst_ovf", {7'b0, overflow}, 8'h00);
    chk("arst_halt", {7'b0, halt}, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("post_rst_empty", {7'b0, tx_valid}, 8'h00);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
